// File: rtl/rectify_pkg.sv
// Shared types for the rectifier frame controller: FSM state encoding and counter widths.
package rectify_pkg;

    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rectify_beat_cnt.sv
// Row/column position of the current beat within a ROW x COL output frame.
module rectify_beat_cnt #(
    parameter int unsigned ROW = 4,
    parameter int unsigned COL = 6,
    parameter int unsigned RW  = 2,
    parameter int unsigned CW  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat,
    input  logic          clear,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic          last
);

    logic col_end;
    logic row_end;

    assign col_end = (col_idx == CW'(COL - 1));
    assign row_end = (row_idx == RW'(ROW - 1));
    assign last    = col_end & row_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (clear) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (beat) begin
            if (col_end) begin
                col_idx <= '0;
                // Final beat wraps the row as well, so non-power-of-two ROW stays in range.
                row_idx <= row_end ? '0 : row_idx + RW'(1);
            end else begin
                col_idx <= col_idx + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rectify_ctrl.sv
// Frame sequencer for the rectifier: start/abort handling, beat tracking, tlast checking.
// Optional watchdog enabled by defining RECTIFY_CTRL_TIMEOUT_EN.
module rectify_ctrl
    import rectify_pkg::*;
#(
    parameter int unsigned ROW     = 4,
    parameter int unsigned COL     = 6,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned RW = (ROW > 1) ? $clog2(ROW) : 1,
    localparam int unsigned CW = (COL > 1) ? $clog2(COL) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    input  logic                   mon_tlast,
    output logic                   run,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_tlast,
    output logic                   timeout,
    output logic [RW-1:0]          row_idx,
    output logic [CW-1:0]          col_idx,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    state_t state, state_nx;
    logic   start_q;
    logic   primed;
    logic   start_edge;
    logic   beat;
    logic   accept;
    logic   count_en;
    logic   last;
    logic   wd_fire;

    // primed blocks the first post-reset cycle so a start held through reset is not an edge.
    assign start_edge = primed & start & ~start_q;
    assign beat       = mon_tvalid & mon_tready;
    assign accept     = (state == IDLE) & start_edge;
    assign count_en   = (state == RUN) & beat & ~abort & ~wd_fire;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start_edge) state_nx = RUN;
            RUN: begin
                if (abort || wd_fire)   state_nx = IDLE;
                else if (beat && last)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            primed     <= 1'b0;
            run        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_tlast  <= 1'b0;
        end else begin
            state      <= state_nx;
            start_q    <= start;
            primed     <= 1'b1;
            run        <= (state_nx == RUN);
            busy       <= (state_nx == RUN) || (state_nx == DONE);
            frame_done <= (state_nx == DONE);
            if (state == DONE)
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            if (accept)
                err_tlast <= 1'b0;
            else if (count_en && (mon_tlast != last))
                err_tlast <= 1'b1;
        end
    end

`ifdef RECTIFY_CTRL_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT) + 1;
    logic [WW-1:0] wd_cnt;

    assign wd_fire = (state == RUN) & ~beat & (wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= ((state == RUN) && !beat) ? wd_cnt + WW'(1) : '0;
            if (accept)
                timeout <= 1'b0;
            else if (wd_fire)
                timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    rectify_beat_cnt #(
        .ROW (ROW),
        .COL (COL),
        .RW  (RW),
        .CW  (CW)
    ) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .beat    (count_en),
        .clear   (accept),
        .row_idx (row_idx),
        .col_idx (col_idx),
        .last    (last)
    );

endmodule

// File: tb/tb_rectify_ctrl.sv
// Self-checking bench for rectify_ctrl: directed frame scenarios plus randomized traffic
// against a frame-level reference model (beat count, phase, sticky flags).
module tb_rectify_ctrl;

    localparam int ROW   = 4;
    localparam int COL   = 6;
    localparam int TO    = 16;
    localparam int BEATS = ROW * COL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic        mon_tlast = 1'b0;
    logic        run, busy, frame_done, err_tlast, timeout;
    logic [1:0]  row_idx;
    logic [2:0]  col_idx;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0=idle 1=running 2=done; m_n = beats taken in this frame.
    int m_phase, m_n, m_cnt, m_wd;
    bit m_err, m_to, m_prev, m_primed;

    rectify_ctrl #(
        .ROW     (ROW),
        .COL     (COL),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .run        (run),
        .busy       (busy),
        .frame_done (frame_done),
        .err_tlast  (err_tlast),
        .timeout    (timeout),
        .row_idx    (row_idx),
        .col_idx    (col_idx),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_cnt = 0; m_wd = 0;
        m_err = 0; m_to = 0; m_prev = 0; m_primed = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit v, input bit r, input bit l);
        bit edge_s, bt, fire, fin;
        edge_s = m_primed && s && !m_prev;
        bt = v && r;
        case (m_phase)
            0: if (edge_s) begin
                m_phase = 1; m_n = 0; m_err = 0; m_to = 0; m_wd = 0;
            end
            1: begin
`ifdef RECTIFY_CTRL_TIMEOUT_EN
                fire = !bt && (m_wd == TO - 1);
`else
                fire = 0;
`endif
                if (a || fire) begin
                    if (fire) m_to = 1;
                    m_phase = 0;
                end else if (bt) begin
                    fin = (m_n == BEATS - 1);
                    if (l != fin) m_err = 1;
                    m_n = (m_n + 1) % BEATS;
                    m_wd = 0;
                    if (fin) m_phase = 2;
                end else begin
                    m_wd++;
                end
            end
            default: begin
                m_phase = 0;
                m_cnt = (m_cnt + 1) % 65536;
            end
        endcase
        m_prev = s;
        m_primed = 1;
    endtask

    task automatic compare_all();
        check("run",        32'(run),        32'(m_phase == 1));
        check("busy",       32'(busy),       32'(m_phase != 0));
        check("frame_done", 32'(frame_done), 32'(m_phase == 2));
        check("err_tlast",  32'(err_tlast),  32'(m_err));
        check("timeout",    32'(timeout),    32'(m_to));
        check("row_idx",    32'(row_idx),    32'(m_n / COL));
        check("col_idx",    32'(col_idx),    32'(m_n % COL));
        check("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
    endtask

    task automatic cycle(input bit s, input bit a, input bit v, input bit r, input bit l);
        start = s; abort = a; mon_tvalid = v; mon_tready = r; mon_tlast = l;
        @(posedge clk);
        model_step(s, a, v, r, l);
        #1;
        compare_all();
    endtask

    task automatic beat(input bit s, input bit l);
        cycle(s, 1'b0, 1'b1, 1'b1, l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_run",       32'(run),        0);
        check("rst_busy",      32'(busy),       0);
        check("rst_done",      32'(frame_done), 0);
        check("rst_err",       32'(err_tlast),  0);
        check("rst_timeout",   32'(timeout),    0);
        check("rst_row",       32'(row_idx),    0);
        check("rst_col",       32'(col_idx),    0);
        check("rst_frame_cnt", 32'(frame_cnt),  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit s, a, v, r, l;
        model_reset();

        // Start held high through reset release must not launch a frame.
        start = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        repeat (3) cycle(1, 0, 0, 0, 0);
        check("held_start_no_frame", 32'(busy), 0);
        cycle(0, 0, 0, 0, 0);

        // Clean frame.
        cycle(1, 0, 0, 0, 0);
        check("s1_run_after_edge", 32'(run), 1);
        for (int i = 1; i <= BEATS; i++) beat(0, i == BEATS);
        check("s1_frame_done", 32'(frame_done), 1);
        cycle(0, 0, 0, 0, 0);
        check("s1_frame_cnt", 32'(frame_cnt), 1);
        check("s1_err", 32'(err_tlast), 0);

        // Early tlast on beat 6.
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= BEATS; i++) begin
            beat(0, i == 6);
            if (i == 6) check("s2_err_after_6", 32'(err_tlast), 1);
            if (i == BEATS - 1) check("s2_still_run", 32'(run), 1);
        end
        check("s2_frame_done", 32'(frame_done), 1);
        cycle(0, 0, 0, 0, 0);
        check("s2_frame_cnt", 32'(frame_cnt), 2);

        // Abort after beat 10, coinciding with a beat.
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) beat(0, 0);
        cycle(0, 1, 1, 1, 0);
        check("s3_run", 32'(run), 0);
        check("s3_busy", 32'(busy), 0);
        check("s3_row", 32'(row_idx), 1);
        check("s3_col", 32'(col_idx), 4);
        cycle(0, 0, 0, 0, 0);
        check("s3_no_done", 32'(frame_done), 0);
        check("s3_frame_cnt", 32'(frame_cnt), 2);

        // Re-pulsed start mid-frame, then start held high past the end.
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) beat(0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 6; i <= BEATS; i++) beat(1, i == BEATS);
        repeat (6) cycle(1, 0, 0, 0, 0);
        check("s4_no_second_frame", 32'(busy), 0);
        check("s4_frame_cnt", 32'(frame_cnt), 3);
        cycle(0, 0, 0, 0, 0);

        // Watchdog: no beats while running.
        cycle(1, 0, 0, 0, 0);
        repeat (TO - 1) cycle(0, 0, 0, 1, 0);
        check("s5_run_before_limit", 32'(run), 1);
        cycle(0, 0, 0, 1, 0);
`ifdef RECTIFY_CTRL_TIMEOUT_EN
        check("s5_timeout", 32'(timeout), 1);
        check("s5_idle", 32'(run), 0);
        cycle(1, 0, 0, 0, 0);
        check("s5_timeout_cleared", 32'(timeout), 0);
        cycle(0, 1, 0, 0, 0);
`else
        check("s5_timeout", 32'(timeout), 0);
        check("s5_still_run", 32'(run), 1);
        cycle(0, 1, 0, 0, 0);
`endif
        check("s5_frame_cnt", 32'(frame_cnt), 3);

        // Reset mid-frame, then a fresh frame counts from 0,0.
        cycle(1, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) beat(0, 0);
        start = 1'b0;
        do_reset();
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("s6_row0", 32'(row_idx), 0);
        check("s6_col0", 32'(col_idx), 0);
        beat(0, 0);
        check("s6_col1", 32'(col_idx), 1);
        cycle(0, 1, 0, 0, 0);

        // Randomized traffic.
        s = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 19) == 0) s = !s;
            a = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) l = ($urandom_range(0, 1) == 1);
            else l = (m_n == BEATS - 1);
            cycle(s, a, v, r, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rectify_ctrl.md
RECTIFY_CTRL -- requirements
Module: rectify_ctrl

Interface
REQ-001 The block SHALL have parameter ROW, default 4: output frame rows.
REQ-002 The block SHALL have parameter COL, default 6: output frame columns.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles without a beat.
REQ-004 The block SHALL have port clk, input, 1: single clock.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start, input, 1: frame request; only the rising edge is significant.
REQ-007 The block SHALL have port abort, input, 1: cancels the current frame.
REQ-008 The block SHALL have ports mon_tvalid, mon_tready and mon_tlast, inputs, 1 each: taps on the rectified output AXI-Stream.
REQ-009 The block SHALL have port run, output, 1: level start to the fetch and coordinate-warper blocks.
REQ-010 The block SHALL have port busy, output, 1: frame in progress.
REQ-011 The block SHALL have port frame_done, output, 1: one-cycle completion pulse.
REQ-012 The block SHALL have port err_tlast, output, 1: sticky tlast-mismatch flag.
REQ-013 The block SHALL have port timeout, output, 1: sticky watchdog flag.
REQ-014 The block SHALL have ports row_idx, output, clog2(ROW), and col_idx, output, clog2(COL): current beat position.
REQ-015 The block SHALL have port frame_cnt, output, 16: number of completed frames.

Function
REQ-016 The block SHALL define a beat as mon_tvalid AND mon_tready sampled on the rising edge of clk.
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN: on a start rising edge, detected against a registered copy of start.
- RUN -> DONE: on the final beat (row_idx=ROW-1, col_idx=COL-1).
- DONE -> IDLE: unconditionally after one cycle.
REQ-018 On entry to RUN, the block SHALL clear row_idx, col_idx and err_tlast.
REQ-019 run and busy SHALL be registered and SHALL go high the cycle after the start edge is sampled.
REQ-020 run SHALL be high only in RUN; busy SHALL be high in RUN and DONE.
REQ-021 On each beat in RUN, col_idx SHALL increment; at COL-1 it SHALL wrap to 0 and row_idx SHALL increment.
REQ-022 row_idx and col_idx SHALL hold when there is no beat.
REQ-023 In the DONE cycle, frame_done SHALL be 1; frame_cnt SHALL increment and wrap modulo 2^16.
REQ-024 err_tlast SHALL be set in either case:
- mon_tlast=1 on a non-final beat;
- mon_tlast=0 on the final beat.
REQ-025 After a tlast error, the frame SHALL still complete on the beat count.
REQ-026 A start edge in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 If abort=1 in RUN, the next state SHALL be IDLE, with run=0, busy=0, no frame_done pulse, frame_cnt unchanged and indices held.
REQ-028 If abort coincides with the final beat, abort SHALL win.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 Beats outside RUN SHALL be ignored.

Reset
REQ-031 While rst=1, the block SHALL be asynchronously in IDLE.
REQ-032 While rst=1, the following SHALL all be 0: run, busy, frame_done, err_tlast, timeout, row_idx, col_idx, frame_cnt, the start edge register and the watchdog counter.
REQ-033 Reset asserted mid-frame SHALL discard the frame with no frame_done pulse.
REQ-034 If start is held high through reset release, the block SHALL NOT start a frame; a fresh rising edge SHALL be required.

Configuration
REQ-035 With macro RECTIFY_CTRL_TIMEOUT_EN defined, a watchdog counter SHALL count RUN cycles without a beat and clear on each beat.
REQ-036 With RECTIFY_CTRL_TIMEOUT_EN defined, the watchdog reaching TIMEOUT-1 SHALL set timeout and act as abort (REQ-027).
REQ-037 With RECTIFY_CTRL_TIMEOUT_EN defined, timeout SHALL clear on the next accepted start.
REQ-038 Without RECTIFY_CTRL_TIMEOUT_EN, the counter SHALL be absent, the timeout port SHALL be present, and timeout SHALL be tied to 0.

Structure
REQ-039 The shared package rectify_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the 16-bit frame counter width constant.
REQ-040 Row/column counting SHALL be one sub-module, rectify_beat_cnt, with inputs beat and clear and outputs row_idx, col_idx and last.

Verification
REQ-041 The bench SHALL cover these scenarios, with ROW=4 and COL=6:
- Start edge, then 24 beats, tlast on beat 24 -> run high for cycles 1..24+, frame_done one cycle after beat 24, frame_cnt=1, err_tlast=0.
- tlast on beat 6 -> err_tlast=1 after beat 6; frame still ends at beat 24.
- abort after beat 10 -> IDLE next cycle, run=0, no frame_done, row_idx=1, col_idx=4, frame_cnt unchanged.
- Start re-pulsed mid-frame, then start held high through 2 frames -> only one frame runs per rising edge; frame_cnt increments by 1 per edge.
- With RECTIFY_CTRL_TIMEOUT_EN and TIMEOUT=16, tvalid held 0 in RUN -> timeout=1 and IDLE after 16 cycles; without the macro, the same stimulus gives timeout=0 and the block stays in RUN.
- rst asserted after beat 12, then start edge -> all outputs 0 immediately; the new frame counts from 0,0.
